nway_cache: RTL and testbench



---
 rtl/nway_cache_pkg.sv | 59 +++++
 rtl/plru_tree.sv | 26 ++
 rtl/nway_cache.sv | 218 +++++++++++++++++++++
 tb/tb_nway_cache.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nway_cache_pkg.sv
// nway_cache_pkg: shared types and helpers for the set-associative cache.
// Holds the controller state encoding, the tree-PLRU victim/update walks
// (written for up to 8 ways, sized at call time by s_way) and the
// line-address helper.
package nway_cache_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  // A node bit of 0 points left, 1 points right; the victim is found by
  // following the bits from the root. Result is right-aligned in 3 bits.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int s_way);
    logic [2:0] way;
    logic [2:0] node;
    logic       b;
    way  = '0;
    node = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < s_way) begin
        b    = bits[node];
        way  = {way[1:0], b};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
      end
    end
    return way;
  endfunction

  // Walk the path of the accessed way and flip every node on it to point
  // away from that way.
  function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                             input int s_way);
    logic [6:0] nb;
    logic [2:0] w;
    logic [2:0] node;
    logic       d;
    nb   = bits;
    w    = way << (3 - s_way);
    node = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < s_way) begin
        d        = w[2];
        nb[node] = ~d;
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, d};
        w        = {w[1:0], 1'b0};
      end
    end
    return nb;
  endfunction

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] line_addr(input logic [31:0] addr, input int s_offset);
    return addr & ~((32'd1 << s_offset) - 32'd1);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// plru_tree: combinational tree-PLRU for one set. Produces the victim way
// from the current node bits and the next node bits after an access to
// access_way.
module plru_tree
  import nway_cache_pkg::*;
#(
  parameter int s_way = 2
) (
  input  logic [2**s_way-2:0] bits,
  input  logic [s_way-1:0]    access_way,
  output logic [s_way-1:0]    victim,
  output logic [2**s_way-2:0] next_bits
);

  logic [2:0] victim_full;
  logic [6:0] next_full;
  logic       unused_hi;

  assign victim_full = plru_victim(7'(bits), s_way);
  assign next_full   = plru_update(7'(bits), 3'(access_way), s_way);
  assign victim      = victim_full[s_way-1:0];
  assign next_bits   = next_full[2**s_way-2:0];
  // Upper bits of the fixed-width helpers are unused for smaller trees.
  assign unused_hi   = ^{victim_full, next_full};

endmodule

// File: rtl/nway_cache.sv
// nway_cache: set-associative, write-back, write-allocate L1 data cache.
// Zero-wait-state hits; misses walk CHECK -> (WRITEBACK) -> FILL -> CHECK,
// and the retried access hits on the cycle after the fill lands.
// Optional performance counters are built when NWAY_CACHE_PERF_EN is
// defined; otherwise the perf_* ports are tied to zero.
module nway_cache
  import nway_cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 2,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [31:0]               mem_address,
  input  logic [2**s_offset-1:0]    mem_byte_enable256,
  input  logic [8*2**s_offset-1:0]  mem_wdata256,
  output logic [8*2**s_offset-1:0]  mem_rdata256,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [31:0]               pmem_address,
  output logic [8*2**s_offset-1:0]  pmem_wdata,
  input  logic [8*2**s_offset-1:0]  pmem_rdata,
  input  logic                      pmem_resp,
  output logic [31:0]               perf_hits,
  output logic [31:0]               perf_misses,
  output logic [31:0]               perf_wbs
);

  localparam int s_line    = 8 * 2**s_offset;
  localparam int num_bytes = 2**s_offset;
  localparam int num_sets  = 2**s_index;
  localparam int num_ways  = 2**s_way;
  localparam int num_nodes = num_ways - 1;

  logic                     req;
  logic [s_index-1:0]       set_idx;
  logic [s_tag-1:0]         tag_in;

  state_t                   state_reg;
  logic [s_way-1:0]         victim_reg;
  logic [num_ways-1:0]      valid_reg [num_sets];
  logic [num_ways-1:0]      dirty_reg [num_sets];
  logic [num_nodes-1:0]     plru_reg  [num_sets];

  logic [num_ways-1:0][s_line-1:0] way_line;
  logic [num_ways-1:0][s_tag-1:0]  way_tag;
  logic [num_ways-1:0]      hit_vec;
  logic                     hit;
  logic [s_way-1:0]         hit_way;
  logic [s_line-1:0]        hit_line;
  logic [s_line-1:0]        merged_line;

  logic [s_way-1:0]         plru_victim_way;
  logic [num_nodes-1:0]     plru_next;
  logic                     inv_found;
  logic [s_way-1:0]         inv_way;
  logic [s_way-1:0]         victim_sel;

  logic                     check_req_hit;
  logic                     hit_wr;
  logic                     fill_done;

  // A simultaneous read and write is treated as a write (mem_write wins).
  assign req     = mem_read | mem_write;
  assign set_idx = mem_address[s_offset+s_index-1:s_offset];
  assign tag_in  = mem_address[31:s_offset+s_index];

  assign check_req_hit = rst && (state_reg == CHECK) && req && hit;
  assign hit_wr        = check_req_hit && mem_write;
  assign fill_done     = rst && (state_reg == FILL) && pmem_resp;

  // Per-way line and tag storage with combinational read at the current set.
  for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
    logic [s_line-1:0] data_mem [num_sets];
    logic [s_tag-1:0]  tag_mem  [num_sets];

    // Fill loads the victim way; a write hit merges into the hit way.
    always_ff @(posedge clk) begin
      if (fill_done && (victim_reg == s_way'(gi))) begin
        data_mem[set_idx] <= pmem_rdata;
        tag_mem[set_idx]  <= tag_in;
      end else if (hit_wr && (hit_way == s_way'(gi))) begin
        data_mem[set_idx] <= merged_line;
      end
    end

    assign way_line[gi] = data_mem[set_idx];
    assign way_tag[gi]  = tag_mem[set_idx];
    assign hit_vec[gi]  = valid_reg[set_idx][gi] && (tag_mem[set_idx] == tag_in);
  end

  // Byte-wise merge of the write data over the current hit line.
  for (genvar gi = 0; gi < num_bytes; gi++) begin : g_byte
    assign merged_line[8*gi +: 8] = mem_byte_enable256[gi] ? mem_wdata256[8*gi +: 8]
                                                           : hit_line[8*gi +: 8];
  end

  // Encode the (at most one) hitting way.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (hit_vec[w]) hit_way = s_way'(w);
    end
  end

  assign hit      = |hit_vec;
  assign hit_line = way_line[hit_way];

  plru_tree #(.s_way(s_way)) u_plru (
    .bits       (plru_reg[set_idx]),
    .access_way (hit_way),
    .victim     (plru_victim_way),
    .next_bits  (plru_next)
  );

  // Victim choice: lowest-index invalid way, else the PLRU victim.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_reg[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = s_way'(w);
      end
    end
    victim_sel = inv_found ? inv_way : plru_victim_way;
  end

  // Miss FSM plus valid/dirty/PLRU bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= CHECK;
      victim_reg <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
    end else begin
      case (state_reg)
        CHECK: begin
          if (req) begin
            if (hit) begin
              plru_reg[set_idx] <= plru_next;
              if (mem_write) dirty_reg[set_idx][hit_way] <= 1'b1;
            end else begin
              victim_reg <= victim_sel;
              state_reg  <= dirty_reg[set_idx][victim_sel] ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_reg[set_idx][victim_reg] <= 1'b0;
            state_reg                      <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid_reg[set_idx][victim_reg] <= 1'b1;
            dirty_reg[set_idx][victim_reg] <= 1'b0;
            state_reg                      <= CHECK;
          end
        end
        default: state_reg <= CHECK;
      endcase
    end
  end

  // CPU and memory-side outputs; all handshakes are held low during reset.
  always_comb begin
    mem_resp     = check_req_hit;
    mem_rdata256 = hit_line;
    pmem_write   = rst && (state_reg == WRITEBACK);
    pmem_read    = rst && (state_reg == FILL);
    pmem_wdata   = way_line[victim_reg];
    if (state_reg == WRITEBACK)
      pmem_address = line_addr({way_tag[victim_reg], set_idx, {s_offset{1'b0}}}, s_offset);
    else
      pmem_address = line_addr(mem_address, s_offset);
  end

`ifdef NWAY_CACHE_PERF_EN
  logic [31:0] hits_reg, misses_reg, wbs_reg;
  logic        check_miss;
  logic        wb_done;

  assign check_miss = rst && (state_reg == CHECK) && req && !hit;
  assign wb_done    = rst && (state_reg == WRITEBACK) && pmem_resp;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hits_reg   <= '0;
      misses_reg <= '0;
      wbs_reg    <= '0;
    end else begin
      if (check_req_hit && (hits_reg != 32'hFFFF_FFFF)) hits_reg <= hits_reg + 32'd1;
      if (check_miss && (misses_reg != 32'hFFFF_FFFF)) misses_reg <= misses_reg + 32'd1;
      if (wb_done && (wbs_reg != 32'hFFFF_FFFF)) wbs_reg <= wbs_reg + 32'd1;
    end
  end

  assign perf_hits   = hits_reg;
  assign perf_misses = misses_reg;
  assign perf_wbs    = wbs_reg;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
  assign perf_wbs    = '0;
`endif

endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: directed, table-driven bench for nway_cache (default
// parameters: 32-byte lines, 8 sets, 4 ways). A small memory model answers
// pmem requests after a fixed latency and logs every completed transfer.
module tb_nway_cache;

  localparam int MEM_LAT = 3;
  localparam logic [255:0] A5_LINE = {32{8'hA5}};
  localparam logic [255:0] MERGED  = {{28{8'hA5}}, 32'h11223344};

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;
  logic [31:0]  perf_wbs;

  nway_cache dut (
    .clk                (clk),
    .rst                (rst),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_wdata256       (mem_wdata256),
    .mem_rdata256       (mem_rdata256),
    .mem_resp           (mem_resp),
    .pmem_read          (pmem_read),
    .pmem_write         (pmem_write),
    .pmem_address       (pmem_address),
    .pmem_wdata         (pmem_wdata),
    .pmem_rdata         (pmem_rdata),
    .pmem_resp          (pmem_resp),
    .perf_hits          (perf_hits),
    .perf_misses        (perf_misses),
    .perf_wbs           (perf_wbs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int exp_wbs  = 0;
  int overlap_cycles = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } ev_t;
  ev_t evq[$];

  logic [255:0] mem_store [logic [31:0]];

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a}};
  endfunction

  function automatic logic [255:0] mem_load(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return pat(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: responds MEM_LAT cycles into a request, logs transfers.
  initial begin
    int lat_cnt;
    ev_t e;
    lat_cnt    = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap_cycles++;
      if (rst && (pmem_read || pmem_write)) begin
        lat_cnt++;
        if (lat_cnt == MEM_LAT) begin
          lat_cnt   = 0;
          pmem_resp = 1'b1;
          e.wr      = pmem_write;
          e.addr    = pmem_address;
          if (pmem_write) begin
            e.data = pmem_wdata;
            mem_store[pmem_address] = pmem_wdata;
          end else begin
            pmem_rdata = mem_load(pmem_address);
            e.data     = pmem_rdata;
          end
          evq.push_back(e);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rst_before;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  be;
    logic [255:0] wdata;
    logic         chk_rd;
    logic [255:0] rdata;
    int           cyc;
    int           nrd;
    int           nwr;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
  } vec_t;
  vec_t vq[$];

  function automatic void add_rd(input logic rb, input logic [31:0] a, input logic [255:0] exp,
                                 input int cyc, input int nrd, input int nwr,
                                 input logic [31:0] wba, input logic [255:0] wbd);
    vec_t v;
    v.rst_before = rb;  v.wr = 1'b0;  v.addr = a;  v.be = '0;  v.wdata = '0;
    v.chk_rd = 1'b1;    v.rdata = exp; v.cyc = cyc; v.nrd = nrd; v.nwr = nwr;
    v.wb_addr = wba;    v.wb_data = wbd;
    vq.push_back(v);
  endfunction

  function automatic void add_wr(input logic [31:0] a, input logic [31:0] be,
                                 input logic [255:0] wd);
    vec_t v;
    v.rst_before = 1'b0; v.wr = 1'b1; v.addr = a; v.be = be; v.wdata = wd;
    v.chk_rd = 1'b0;     v.rdata = '0; v.cyc = 1; v.nrd = 0; v.nwr = 0;
    v.wb_addr = '0;      v.wb_data = '0;
    vq.push_back(v);
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    exp_wbs  = 0;
  endtask

  task automatic check_perf(input string name);
`ifdef NWAY_CACHE_PERF_EN
    check(name, {perf_hits, perf_misses, perf_wbs},
          {32'(exp_hits), 32'(exp_miss), 32'(exp_wbs)});
`else
    check(name, {perf_hits, perf_misses, perf_wbs}, '0);
`endif
  endtask

  // Apply one access (mem_read held high; writes also raise mem_write) and
  // compare response latency, data, memory traffic and counters.
  task automatic run_vec(input vec_t v, input int idx);
    logic [255:0] rd;
    int           cyc;
    logic         got;
    int           n_rd;
    int           n_wr;
    if (v.rst_before) pulse_reset();
    evq.delete();
    @(posedge clk); #1;
    mem_read           = 1'b1;
    mem_write          = v.wr;
    mem_address        = v.addr;
    mem_byte_enable256 = v.be;
    mem_wdata256       = v.wdata;
    cyc = 0;
    got = 1'b0;
    rd  = '0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        got = 1'b1;
        rd  = mem_rdata256;
      end
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    if (got) exp_hits++;
    if (v.cyc > 1) exp_miss++;
    exp_wbs += v.nwr;

    n_rd = 0;
    n_wr = 0;
    foreach (evq[k]) begin
      if (evq[k].wr) n_wr++;
      else n_rd++;
    end

    $display("txn %0d %s addr=%h cycles=%0d pmem_rd=%0d pmem_wr=%0d rdata=%h",
             idx, v.wr ? "wr" : "rd", v.addr, cyc, n_rd, n_wr, rd);

    check($sformatf("v%0d resp", idx), got, 1);
    check($sformatf("v%0d cycles", idx), cyc, v.cyc);
    if (v.chk_rd) check($sformatf("v%0d rdata", idx), rd, v.rdata);
    check($sformatf("v%0d pmem reads", idx), n_rd, v.nrd);
    check($sformatf("v%0d pmem writes", idx), n_wr, v.nwr);
    if (v.nwr > 0 && evq.size() > 0) begin
      check($sformatf("v%0d first is writeback", idx), evq[0].wr, 1);
      check($sformatf("v%0d wb addr", idx), evq[0].addr, v.wb_addr);
      check($sformatf("v%0d wb data", idx), evq[0].data, v.wb_data);
    end
    if (v.nrd > 0 && evq.size() > 0)
      check($sformatf("v%0d fill addr", idx), evq[evq.size()-1].addr, v.addr & ~32'h1F);
    check_perf($sformatf("v%0d perf", idx));
  endtask

  initial begin
    logic seen;
    int   idx;
    rst                = 1'b0;
    mem_read           = 1'b1;
    mem_write          = 1'b0;
    mem_address        = 32'h1000;
    mem_byte_enable256 = '0;
    mem_wdata256       = '0;
    mem_store[32'h1000] = A5_LINE;

    // Handshakes must stay low while reset is held, even with a request up.
    repeat (3) @(negedge clk);
    check("reset outputs", {mem_resp, pmem_read, pmem_write}, '0);
    check_perf("reset perf");
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_read = 1'b0;

    // Fill, hit, byte-masked write, readback, dirty eviction via set 0.
    add_rd(0, 32'h1000, A5_LINE,      5, 1, 0, '0, '0);
    add_rd(0, 32'h1000, A5_LINE,      1, 0, 0, '0, '0);
    add_wr(32'h1000, 32'h0000_000F, {8{32'h11223344}});
    add_rd(0, 32'h1000, MERGED,       1, 0, 0, '0, '0);
    add_rd(0, 32'h2000, pat(32'h2000), 5, 1, 0, '0, '0);
    add_rd(0, 32'h3000, pat(32'h3000), 5, 1, 0, '0, '0);
    add_rd(0, 32'h4000, pat(32'h4000), 5, 1, 0, '0, '0);
    add_rd(0, 32'h5000, pat(32'h5000), 8, 1, 1, 32'h1000, MERGED);
    add_rd(0, 32'h1000, MERGED,       5, 1, 0, '0, '0);
    add_rd(0, 32'h2000, pat(32'h2000), 1, 0, 0, '0, '0);
    add_rd(0, 32'h4000, pat(32'h4000), 1, 0, 0, '0, '0);
    // PLRU: after reset fill ways 0..3, touch way 0, then 0x400 must evict way 2.
    add_rd(1, 32'h000, pat(32'h000),  5, 1, 0, '0, '0);
    add_rd(0, 32'h100, pat(32'h100),  5, 1, 0, '0, '0);
    add_rd(0, 32'h200, pat(32'h200),  5, 1, 0, '0, '0);
    add_rd(0, 32'h300, pat(32'h300),  5, 1, 0, '0, '0);
    add_rd(0, 32'h000, pat(32'h000),  1, 0, 0, '0, '0);
    add_rd(0, 32'h400, pat(32'h400),  5, 1, 0, '0, '0);
    add_rd(0, 32'h000, pat(32'h000),  1, 0, 0, '0, '0);
    add_rd(0, 32'h100, pat(32'h100),  1, 0, 0, '0, '0);
    add_rd(0, 32'h300, pat(32'h300),  1, 0, 0, '0, '0);
    add_rd(0, 32'h200, pat(32'h200),  5, 1, 0, '0, '0);

    idx = 0;
    foreach (vq[i]) begin
      run_vec(vq[i], idx);
      idx++;
    end

    // Reset while a fill is outstanding.
    evq.delete();
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = 32'h1000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    check("midfill pmem_read seen", seen, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midfill outputs in reset", {mem_resp, pmem_read, pmem_write}, '0);
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    exp_wbs  = 0;
    @(negedge clk);
    check("midfill outputs after reset", {mem_resp, pmem_read, pmem_write}, '0);
    check("midfill no transfer", evq.size(), 0);
    check_perf("midfill perf cleared");

    // Every line is invalid again: both lookups miss.
    vq.delete();
    add_rd(0, 32'h1000, MERGED,        5, 1, 0, '0, '0);
    add_rd(0, 32'h300,  pat(32'h300),  5, 1, 0, '0, '0);
    foreach (vq[i]) begin
      run_vec(vq[i], idx);
      idx++;
    end

    check("pmem read/write overlap cycles", overlap_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
